// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one combinational round reused for ten clocked
// iterations, with an InvMixColumns + AddRoundKey stage producing the ciphertext.
package aes128_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as b^254 by square-and-multiply (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09)};
    endfunction
endpackage

module aes_round_umsk
    import aes128_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);
    logic [127:0] ark;
    logic [127:0] sr;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  w0, w1, w2, w3;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        sr        = '0;
        state_out = '0;
        sub       = '0;
        ark       = state_in ^ key_in;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[8*(r + 4*c) +: 8] = sbox(ark[8*(r + 4*((c + r) % 4)) +: 8]);
        for (int c = 0; c < 4; c++)
            state_out[32*c +: 32] = mix_col(sr[32*c +: 32]);

        rot = {key_in[103:96], key_in[127:104]};
        for (int i = 0; i < 4; i++)
            sub[8*i +: 8] = sbox(rot[8*i +: 8]);
        sub[7:0] = sub[7:0] ^ rcon;
        w0       = key_in[31:0]   ^ sub;
        w1       = key_in[63:32]  ^ w0;
        w2       = key_in[95:64]  ^ w1;
        w3       = key_in[127:96] ^ w2;
        key_out  = {w3, w2, w1, w0};
    end
endmodule

module aes128_enc_iter
    import aes128_pkg::*;
#(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] ct_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   rnd_cnt;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [127:0] ct_next;

    aes_round_umsk u_round (
        .state_in  (state_reg),
        .key_in    (key_reg),
        .rcon      (rcon_reg),
        .state_out (state_out),
        .key_out   (key_out)
    );

    // The round always includes MixColumns, so the last round undoes it here.
    always_comb begin
        ct_next = '0;
        for (int c = 0; c < 4; c++)
            ct_next[32*c +: 32] = inv_mix_col(state_out[32*c +: 32]) ^ key_out[32*c +: 32];
    end

    assign ciphertext = ct_reg;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state_reg <= '0;
            key_reg   <= '0;
            ct_reg    <= '0;
            rcon_reg  <= 8'h01;
            rnd_cnt   <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    state_reg <= plaintext;
                    key_reg   <= key;
                    rcon_reg  <= 8'h01;
                    rnd_cnt   <= 4'd1;
                    in_ready  <= 1'b0;
                    fsm       <= RUN;
                end
                RUN: begin
                    state_reg <= state_out;
                    key_reg   <= key_out;
                    rcon_reg  <= xtime(rcon_reg);
                    rnd_cnt   <= rnd_cnt + 4'd1;
                    if (rnd_cnt == 4'd10) begin
                        ct_reg    <= ct_next;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm       <= IDLE;
                    if (CLEAR_ON_DONE) begin
                        state_reg <= '0;
                        key_reg   <= '0;
                        ct_reg    <= '0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption core built around the existing combinational round `aes_round_umsk`.
- Holds state and round-key registers, sequences RCON, and drives one `aes_round_umsk` instance for 10 clocked iterations.
- Finishes with an inverse-MixColumns stage plus the final AddRoundKey to produce the ciphertext.
- Sits between a valid/ready plaintext+key source and a valid/ready ciphertext sink. It is the sequencing stage that feeds and consumes the round datapath.

Parameters:
- CLEAR_ON_DONE, 1: when 1, state_reg, key_reg and ct_reg are zeroed on the output handshake. When 0, they retain their values.

Ports:
- clk  input  1  clock; all registers on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  core can accept a block.
- plaintext  input  128  byte 0 (FIPS order) in bits [7:0].
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  sink accepts ciphertext.
- ciphertext  output  128  result, same byte order.

Behaviour:
- Round primitive: `aes_round_umsk` computes `state_out = MC(SR(SB(state_in ^ key_in)))` and `key_out = next round key` using `RCON`. The instance is combinational, and its inputs are `state_reg`, `key_reg` and `rcon_reg`.
- Reset (async, rst_n=0): FSM=IDLE; in_ready=1; out_valid=0; ciphertext=0; state_reg, key_reg, ct_reg = 0; rcon_reg=8'h01; rnd_cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg<=plaintext, key_reg<=key, rcon_reg<=8'h01, rnd_cnt<=1, go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored; no buffering.
  - Each cycle: state_reg<=state_out, key_reg<=key_out, rcon_reg<=xtime(rcon_reg), i.e. `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0)`, rnd_cnt<=rnd_cnt+1.
  - RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
  - When rnd_cnt==10, the same edge instead loads `ct_reg <= InvMixColumns(state_out) ^ key_out`, sets out_valid=1 and goes to DONE.
  - state_reg/key_reg update normally on that edge.
- Latency: the acceptance edge is edge 0, and out_valid rises after edge 10. Exactly 10 cycles in RUN.
- DONE:
  - out_valid=1; ciphertext=ct_reg, stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0, go to IDLE, apply the CLEAR_ON_DONE rule.
- Throughput: one block per 12 cycles minimum, with in_ready high one cycle after the output handshake.
- InvMixColumns: per column, GF(2^8) multiplication by {0e,0b,0d,09} with polynomial 0x11b. Combinational, feeding ct_reg only.
- Reset mid-RUN or mid-DONE: immediate return to reset values. No ciphertext is emitted and the partial state is cleared.
- ciphertext is driven from ct_reg only; no combinational path from inputs to outputs.
- in_ready is a pure function of FSM state.

Test Plan:
- FIPS-197 App. B vector:
  - Stimulus: key=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, pt=128'h340737e0_a2983131_8d305a88_a8f64332, out_ready=1.
  - Required: one cycle after acceptance, state_reg=128'h4c260628_7ad3f848_9a19cbe0_e5816604 and key_reg=128'h05766c2a_3939a323_b12c5488_17fefaa0.
  - Required: out_valid after exactly 10 cycles with ciphertext=128'h320b6a19_978511dc_fb09dc02_1d842539.
- FIPS-197 App. C.1:
  - Stimulus: key=128'h0f0e0d0c_0b0a0908_07060504_03020100, pt=128'hffeeddcc_bbaa9988_77665544_33221100.
  - Required: ciphertext=128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: ciphertext and out_valid stay stable and in_ready stays 0. Handshake on the 6th cycle, then in_ready=1 next cycle; internal registers=0 with CLEAR_ON_DONE=1.
- Busy input:
  - Stimulus: toggle in_valid with different data during RUN.
  - Required: the result is still the App. B ciphertext.
- Reset mid-operation:
  - Stimulus: drop rst_n at round 5.
  - Required: out_valid=0, in_ready=1, ciphertext=0 immediately. A fresh App. C.1 run then completes correctly.
- Back-to-back:
  - Stimulus: App. B then App. C.1 with in_valid held high.
  - Required: both correct, in order, at 12-cycle spacing; rcon restarts at 01 for the second block.
